adc_spi_sampler: RTL and testbench

Upstream acquisition stage for the fan controller. Every sample period it runs a burst of conversions on an external 8-bit serial (SPI mode 0) temperature ADC and averages them. It then presents the result together with a one-cycle valid strobe, and these feed the controller's `ADC_value_i` and `dataVaild_STRB_i` inputs directly. It replaces the manual strobe pin, so the control loop gets a regular 10 ms time step.

---
 rtl/adc_spi_sampler_if.sv | 22 ++
 rtl/adc_spi_sampler.sv | 199 +++++++++++++++++++
 tb/tb_adc_spi_sampler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_sampler_if.sv
// Bus between the ADC sampler and its surroundings: the SPI pins of the
// temperature ADC plus the averaged result presented to the fan controller.
interface adc_spi_sampler_if #(
  parameter int ADC_BITWIDTH = 8
);
  logic                    adc_miso_i;
  logic                    adc_cs_n_o;
  logic                    adc_sclk_o;
  logic [ADC_BITWIDTH-1:0] ADC_value_o;
  logic                    dataVaild_STRB_o;
  logic                    busy_o;

  modport master (
    input  adc_miso_i,
    output adc_cs_n_o, adc_sclk_o, ADC_value_o, dataVaild_STRB_o, busy_o
  );

  modport slave (
    output adc_miso_i,
    input  adc_cs_n_o, adc_sclk_o, ADC_value_o, dataVaild_STRB_o, busy_o
  );
endinterface

// File: rtl/adc_spi_sampler.sv
// Periodic burst sampler for an 8-bit SPI mode-0 ADC: every SAMPLE_PERIOD enabled
// cycles it runs 2^AVG_LOG2 conversions and strobes out their truncated average.
module adc_spi_sampler #(
  parameter int ADC_BITWIDTH  = 8,
  parameter int FRAME_BITS    = 16,
  parameter int DATA_START    = 3,
  parameter int CLK_DIV       = 5,
  parameter int AVG_LOG2      = 2,
  parameter int SAMPLE_PERIOD = 100000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clk_en_i,
  input  logic                   en_i,
  adc_spi_sampler_if.master      bus
);
  localparam int PER_W  = $clog2(SAMPLE_PERIOD);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int BIT_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int CONV_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACC_W  = ADC_BITWIDTH + AVG_LOG2;

  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'((1 << AVG_LOG2) - 1);
  localparam logic [BIT_W:0]    DATA_LO   = (BIT_W+1)'(DATA_START);
  localparam logic [BIT_W:0]    DATA_HI   = (BIT_W+1)'(DATA_START + ADC_BITWIDTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [PER_W-1:0]        per_cnt_r, per_cnt_s;
  logic [DIV_W-1:0]        div_cnt_r, div_cnt_s;
  logic [BIT_W-1:0]        bit_cnt_r, bit_cnt_s;
  logic [CONV_W-1:0]       conv_cnt_r, conv_cnt_s;
  logic [ADC_BITWIDTH-1:0] shreg_r, shreg_s;
  logic [ACC_W-1:0]        acc_r, acc_s;
  logic [ADC_BITWIDTH-1:0] value_r, value_s;
  logic                    miso_r;
  logic                    cs_n_r, cs_n_s;
  logic                    sclk_r, sclk_s;
  logic                    strobe_r, strobe_s;
  logic                    busy_r, busy_s;
  logic                    trig_s, div_last_s, in_data_s;

  assign trig_s     = clk_en_i && en_i && (per_cnt_r == PER_LAST);
  assign div_last_s = (div_cnt_r == DIV_LAST);
  assign in_data_s  = ({1'b0, bit_cnt_r} >= DATA_LO) && ({1'b0, bit_cnt_r} < DATA_HI);

  // Next-state, counter and output computation; SCLK/CS are precomputed so they leave straight from flops
  always_comb begin
    state_s    = state_r;
    div_cnt_s  = div_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    conv_cnt_s = conv_cnt_r;
    shreg_s    = shreg_r;
    acc_s      = acc_r;
    value_s    = value_r;
    cs_n_s     = cs_n_r;
    sclk_s     = sclk_r;
    strobe_s   = 1'b0;
    busy_s     = busy_r;

    if (!en_i) begin
      per_cnt_s = '0;
    end else if (clk_en_i) begin
      per_cnt_s = trig_s ? '0 : per_cnt_r + 1'b1;
    end else begin
      per_cnt_s = per_cnt_r;
    end

    case (state_r)
      ST_IDLE: begin
        cs_n_s = 1'b1;
        sclk_s = 1'b0;
        if (trig_s) begin
          state_s    = ST_CS_SETUP;
          acc_s      = '0;
          conv_cnt_s = '0;
          div_cnt_s  = '0;
          cs_n_s     = 1'b0;
          busy_s     = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CS_SETUP: begin
        if (clk_en_i && div_last_s) begin
          state_s   = ST_SHIFT;
          div_cnt_s = '0;
          bit_cnt_s = '0;
          sclk_s    = 1'b1;
        end else if (clk_en_i) begin
          div_cnt_s = div_cnt_r + 1'b1;
        end else begin
          div_cnt_s = div_cnt_r;
        end
      end
      ST_SHIFT: begin
        if (clk_en_i && div_last_s) begin
          div_cnt_s = '0;
          if (sclk_r) begin
            // Last enabled cycle of the high phase: capture only data-field bits
            sclk_s = 1'b0;
            if (in_data_s) begin
              shreg_s = ADC_BITWIDTH'({shreg_r, miso_r});
            end else begin
              shreg_s = shreg_r;
            end
          end else if (bit_cnt_r == BIT_LAST) begin
            state_s = ST_CS_HOLD;
            cs_n_s  = 1'b1;
            acc_s   = acc_r + ACC_W'(shreg_r);
          end else begin
            bit_cnt_s = bit_cnt_r + 1'b1;
            sclk_s    = 1'b1;
          end
        end else if (clk_en_i) begin
          div_cnt_s = div_cnt_r + 1'b1;
        end else begin
          div_cnt_s = div_cnt_r;
        end
      end
      ST_CS_HOLD: begin
        if (clk_en_i && div_last_s) begin
          div_cnt_s = '0;
          if (conv_cnt_r == CONV_LAST) begin
            state_s  = ST_DONE;
            value_s  = ADC_BITWIDTH'(acc_r >> AVG_LOG2);
            strobe_s = 1'b1;
            busy_s   = 1'b0;
          end else begin
            state_s    = ST_CS_SETUP;
            conv_cnt_s = conv_cnt_r + 1'b1;
            cs_n_s     = 1'b0;
          end
        end else if (clk_en_i) begin
          div_cnt_s = div_cnt_r + 1'b1;
        end else begin
          div_cnt_s = div_cnt_r;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cs_n_s  = 1'b1;
        sclk_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    miso_r <= bus.adc_miso_i;
    if (rst_i) begin
      state_r    <= ST_IDLE;
      per_cnt_r  <= '0;
      div_cnt_r  <= '0;
      bit_cnt_r  <= '0;
      conv_cnt_r <= '0;
      shreg_r    <= '0;
      acc_r      <= '0;
      value_r    <= '0;
      cs_n_r     <= 1'b1;
      sclk_r     <= 1'b0;
      strobe_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      per_cnt_r  <= per_cnt_s;
      div_cnt_r  <= div_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      conv_cnt_r <= conv_cnt_s;
      shreg_r    <= shreg_s;
      acc_r      <= acc_s;
      value_r    <= value_s;
      cs_n_r     <= cs_n_s;
      sclk_r     <= sclk_s;
      strobe_r   <= strobe_s;
      busy_r     <= busy_s;
    end
  end

  assign bus.adc_cs_n_o       = cs_n_r;
  assign bus.adc_sclk_o       = sclk_r;
  assign bus.ADC_value_o      = value_r;
  assign bus.dataVaild_STRB_o = strobe_r;
  assign bus.busy_o           = busy_r;
endmodule

// File: tb/tb_adc_spi_sampler.sv
// Two sampler instances (4-sample average at 1000-cycle period, and single
// conversion at a 150-cycle period that overruns) against a behavioural ADC model.
module tb_adc_spi_sampler;
  localparam int CLK_DIV = 5;
  localparam int FB      = 16;
  localparam int DS      = 3;
  localparam int SP_A    = 1000;
  localparam int SP_B    = 150;
  localparam int BLEN_A  = 4 * 2 * CLK_DIV * (FB + 1);
  localparam int BLEN_B  = 2 * CLK_DIV * (FB + 1);

  logic clk;
  logic [1:0] rst, en, clk_en, half;
  logic [1:0] cs_n, sclk, stb, busy;
  logic [1:0][7:0] val;

  adc_spi_sampler_if #(.ADC_BITWIDTH(8)) bus_a ();
  adc_spi_sampler_if #(.ADC_BITWIDTH(8)) bus_b ();

  adc_spi_sampler #(.SAMPLE_PERIOD(SP_A)) dut_a (
    .clk_i(clk), .rst_i(rst[0]), .clk_en_i(clk_en[0]), .en_i(en[0]), .bus(bus_a)
  );
  adc_spi_sampler #(.AVG_LOG2(0), .SAMPLE_PERIOD(SP_B)) dut_b (
    .clk_i(clk), .rst_i(rst[1]), .clk_en_i(clk_en[1]), .en_i(en[1]), .bus(bus_b)
  );

  assign cs_n = {bus_b.adc_cs_n_o, bus_a.adc_cs_n_o};
  assign sclk = {bus_b.adc_sclk_o, bus_a.adc_sclk_o};
  assign stb  = {bus_b.dataVaild_STRB_o, bus_a.dataVaild_STRB_o};
  assign busy = {bus_b.busy_o, bus_a.busy_o};
  assign val  = {bus_b.ADC_value_o, bus_a.ADC_value_o};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int avg_l [2] = '{2, 0};
  int blen  [2] = '{BLEN_A, BLEN_B};
  int exp_int [2] = '{SP_A, 2 * SP_B};
  logic [7:0] fixed_w [12] = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd255, 8'd255,
                               8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd3};
  int wi [2];
  int sum [2], cnt [2], conv_no [2], rises [2], hi_len [2], bit_idx [2];
  int burst_start [2], lat_factor [2], last_stb [2], first_stb [2];
  int stb_cnt [2], cs_falls [2], res_n [2];
  logic [7:0] first_res [2][3];
  logic [15:0] frame [2];
  logic [1:0] prev_cs, prev_sclk, prev_stb;
  logic [7:0] w_t;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_miso(input int i, input logic b);
    if (i == 0) bus_a.adc_miso_i = b;
    else        bus_b.adc_miso_i = b;
  endtask

  task automatic wait_next_stb(input int i, input int budget, input string tag);
    int start;
    int ok;
    start = stb_cnt[i];
    ok = 0;
    for (int k = 0; k < budget && ok == 0; k++) begin
      @(negedge clk);
      if (stb_cnt[i] > start) ok = 1;
    end
    check_eq(tag, ok, 1);
  endtask

  // ADC model and scoreboard, sampled 1 time unit after each rising clock edge
  initial begin
    for (int i = 0; i < 2; i++) begin
      wi[i] = 0; sum[i] = 0; cnt[i] = 0; conv_no[i] = 0; rises[i] = 0; hi_len[i] = 0;
      bit_idx[i] = 0; burst_start[i] = 0; lat_factor[i] = 1; last_stb[i] = -1;
      first_stb[i] = -1; stb_cnt[i] = 0; cs_falls[i] = 0; res_n[i] = 0;
      drive_miso(i, 1'b0);
    end
    prev_cs = 2'b11; prev_sclk = 2'b00; prev_stb = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (rst[i]) begin
          sum[i] = 0; cnt[i] = 0; conv_no[i] = 0; rises[i] = 0; hi_len[i] = 0;
          last_stb[i] = -1;
          prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; prev_stb[i] = 1'b0;
          clk_en[i] = 1'b1;
          drive_miso(i, 1'b0);
        end else begin
          if (prev_stb[i]) check_eq($sformatf("stb_width_%0d", i), stb[i], 0);
          if (stb[i]) begin
            check_eq($sformatf("conv_count_%0d", i), cnt[i], 1 << avg_l[i]);
            check_eq($sformatf("value_%0d", i), val[i], (sum[i] >> avg_l[i]) & 255);
            check_eq($sformatf("latency_%0d", i), cyc - burst_start[i], blen[i] * lat_factor[i]);
            if (last_stb[i] >= 0)
              check_eq($sformatf("interval_%0d", i), cyc - last_stb[i], exp_int[i]);
            if (first_stb[i] < 0) first_stb[i] = cyc;
            if (res_n[i] < 3) begin
              first_res[i][res_n[i]] = val[i];
              res_n[i]++;
            end
            last_stb[i] = cyc;
            stb_cnt[i]++;
            sum[i] = 0; cnt[i] = 0; conv_no[i] = 0;
          end
          if (prev_cs[i] && !cs_n[i]) begin
            if (conv_no[i] == 0) begin
              burst_start[i] = cyc;
              lat_factor[i] = half[i] ? 2 : 1;
            end
            check_eq($sformatf("busy_in_burst_%0d", i), busy[i], 1);
            if (i == 0 && wi[0] < 12) begin
              w_t = fixed_w[wi[0]];
              wi[0]++;
            end else if (i == 1 && wi[1] == 0) begin
              w_t = 8'hA5;
              wi[1]++;
            end else begin
              w_t = 8'($urandom_range(0, 255));
            end
            frame[i] = (i == 0) ? 16'hFFFF : 16'($urandom);
            for (int j = 0; j < 8; j++) frame[i][DS + j] = w_t[7 - j];
            sum[i] += int'(w_t);
            cnt[i]++;
            conv_no[i]++;
            cs_falls[i]++;
            rises[i] = 0;
            bit_idx[i] = 0;
            drive_miso(i, frame[i][0]);
          end
          if (!prev_sclk[i] && sclk[i]) rises[i]++;
          if (prev_sclk[i] && !sclk[i]) begin
            check_eq($sformatf("sclk_high_%0d", i), hi_len[i], CLK_DIV * lat_factor[i]);
            bit_idx[i]++;
            drive_miso(i, (bit_idx[i] < FB) ? frame[i][bit_idx[i]] : 1'b0);
          end
          if (sclk[i]) hi_len[i] = prev_sclk[i] ? hi_len[i] + 1 : 1;
          if (!prev_cs[i] && cs_n[i]) check_eq($sformatf("sclk_rises_%0d", i), rises[i], FB);
          prev_cs[i] = cs_n[i];
          prev_sclk[i] = sclk[i];
          prev_stb[i] = stb[i];
          clk_en[i] = half[i] ? ~clk_en[i] : 1'b1;
        end
      end
    end
  end

  // Directed sequence on instance A; instance B free-runs in overrun mode
  initial begin
    int rel;
    int falls;
    int ok;
    rst = 2'b11; en = 2'b11; clk_en = 2'b11; half = 2'b00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_cs_%0d", i), cs_n[i], 1);
      check_eq($sformatf("rst_sclk_%0d", i), sclk[i], 0);
      check_eq($sformatf("rst_value_%0d", i), val[i], 0);
      check_eq($sformatf("rst_stb_%0d", i), stb[i], 0);
      check_eq($sformatf("rst_busy_%0d", i), busy[i], 0);
    end
    rst = 2'b00;
    rel = cyc;

    wait_next_stb(0, 2000, "tmo_avg1");
    check_eq("first_stb_a", last_stb[0], rel + SP_A + BLEN_A);
    check_eq("first_stb_b", first_stb[1], rel + SP_B + BLEN_B);
    check_eq("passthru_b", first_res[1][0], 8'hA5);
    wait_next_stb(0, 1200, "tmo_avg2");
    wait_next_stb(0, 1200, "tmo_avg3");
    check_eq("avg_10_13", first_res[0][0], 11);
    check_eq("avg_ff", first_res[0][1], 255);
    check_eq("avg_trunc", first_res[0][2], 0);
    wait_next_stb(0, 1200, "tmo_avg4");

    ok = 0;
    for (int k = 0; k < 1500 && ok == 0; k++) begin
      @(negedge clk);
      if (conv_no[0] == 2 && rises[0] == 8) ok = 1;
    end
    check_eq("tmo_bit7", ok, 1);
    rst[0] = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_cs", cs_n[0], 1);
    check_eq("mid_rst_sclk", sclk[0], 0);
    check_eq("mid_rst_value", val[0], 0);
    check_eq("mid_rst_busy", busy[0], 0);
    check_eq("mid_rst_stb", stb[0], 0);
    rst[0] = 1'b0;
    rel = cyc;
    wait_next_stb(0, 2000, "tmo_after_rst");
    check_eq("stb_after_rst", last_stb[0], rel + SP_A + BLEN_A);

    half[0] = 1'b1;
    last_stb[0] = -1;
    wait_next_stb(0, 4000, "tmo_half_clk_en");
    half[0] = 1'b0;
    last_stb[0] = -1;
    wait_next_stb(0, 2500, "tmo_full_clk_en");

    en[0] = 1'b0;
    last_stb[0] = -1;
    falls = cs_falls[0];
    repeat (3 * SP_A) @(negedge clk);
    check_eq("en_off_no_cs", cs_falls[0], falls);
    en[0] = 1'b1;
    rel = cyc;
    wait_next_stb(0, 2000, "tmo_en_on");
    check_eq("stb_after_en", last_stb[0], rel + SP_A + BLEN_A);

    ok = 0;
    for (int k = 0; k < 1500 && ok == 0; k++) begin
      @(negedge clk);
      if (busy[0]) ok = 1;
    end
    check_eq("tmo_busy", ok, 1);
    en[0] = 1'b0;
    wait_next_stb(0, 1000, "en_drop_stb");
    falls = cs_falls[0];
    repeat (2500) @(negedge clk);
    check_eq("en_drop_no_cs", cs_falls[0], falls);
    check_eq("b_strobes", (stb_cnt[1] >= 20) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
